// File: rtl/imem_ld_pkg.sv
// rtl/imem_ld_pkg.sv - shared state encoding and byte/word geometry for the imem boot loader
package imem_ld_pkg;
  typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERROR} ld_state_t;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - assembles four stream bytes little-endian into one word
module byte_packer
  import imem_ld_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic [31:0]       word,
  output logic              word_valid
);
  logic [1:0]  cnt;
  logic [23:0] lo;

  // Only the low three bytes are stored; the fourth completes the word combinationally.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 2'd0;
      lo  <= 24'd0;
    end else if (in_valid) begin
      cnt <= cnt + 2'd1;
      if (cnt != 2'd3)
        lo[{cnt, 3'b000} +: BYTE_W] <= in_data;
    end
  end

  assign word       = {in_data, lo};
  assign word_valid = in_valid && (cnt == 2'd3);
endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a byte-streamed program into imem, then releases the core
module imem_boot_loader
  import imem_ld_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [WIDTH-1:0]  cpu_pc,
  output logic [WIDTH-1:0]  imem_pc,
  output logic              imem_write_enable,
  output logic [WIDTH-1:0]  imem_write_addr,
  output logic [WIDTH-1:0]  imem_write_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);
  localparam int CW = $clog2(SIZE + 1);

  ld_state_t   state;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] n_words;
  logic [31:0] word;
  logic        word_valid;
  logic        transfer;

  // Once every word has been accepted, stop taking bytes while the last write drains.
  assign rx_ready = (state == HDR) || ((state == LOAD) && (word_cnt != n_words));
  assign transfer = rx_valid && rx_ready;
  assign imem_pc  = (state == DONE) ? cpu_pc : '0;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (!((state == HDR) || (state == LOAD))),
    .in_data    (rx_data),
    .in_valid   (transfer),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      imem_write_enable <= 1'b0;
      imem_write_addr   <= '0;
      imem_write_data   <= '0;
      cpu_hold          <= 1'b1;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      word_cnt          <= '0;
      n_words           <= '0;
    end else begin
      imem_write_enable <= 1'b0;
      case (state)
        IDLE: if (load_start) state <= HDR;
        HDR: if (word_valid) begin
          word_cnt <= '0;
          if (word == 32'd0) begin
            n_words   <= '0;
            state     <= DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end else if (word > 32'(SIZE)) begin
            state      <= ERROR;
            load_error <= 1'b1;
          end else begin
            n_words <= word[CW-1:0];
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (word_valid) begin
            imem_write_enable <= 1'b1;
            imem_write_addr   <= {{(WIDTH-CW){1'b0}}, word_cnt};
            imem_write_data   <= word;
            word_cnt          <= word_cnt + 1'b1;
          end
          // Reached only during the final write cycle, so release follows the last strobe.
          if (word_cnt == n_words) begin
            state     <= DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end
        end
        DONE, ERROR: if (load_start) begin
          state      <= HDR;
          cpu_hold   <= 1'b1;
          load_done  <= 1'b0;
          load_error <= 1'b0;
          word_cnt   <= '0;
          n_words    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] cpu_pc = 32'h0000_0040;
  logic [31:0] imem_pc;
  logic        imem_write_enable;
  logic [31:0] imem_write_addr;
  logic [31:0] imem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.WIDTH(32), .SIZE(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .load_start        (load_start),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .cpu_pc            (cpu_pc),
    .imem_pc           (imem_pc),
    .imem_write_enable (imem_write_enable),
    .imem_write_addr   (imem_write_addr),
    .imem_write_data   (imem_write_data),
    .cpu_hold          (cpu_hold),
    .load_done         (load_done),
    .load_error        (load_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (imem_write_enable) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got addr %h data %h expected none", imem_write_addr, imem_write_data);
      end else begin
        check("wr_addr", imem_write_addr, exp_addr_q.pop_front());
        check("wr_data", imem_write_data, exp_data_q.pop_front());
        check("hold_during_write", {31'd0, cpu_hold}, 32'd1);
      end
    end
  end

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit sent = 1'b0;
    for (int c = 0; c < 200 && !sent; c++) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready) begin
          @(posedge clk);
          sent = 1'b1;
        end
      end
    end
    if (!sent) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid   = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Program of test 2: header then two words, checks release timing after last byte.
  task automatic load_two(input bit gaps);
    expect_write(32'd0, 32'h0010_0513);
    expect_write(32'd1, 32'h0020_0593);
    send_word(32'd2, gaps);
    send_word(32'h0010_0513, gaps);
    send_word(32'h0020_0593, gaps);
    @(negedge clk);
    rx_valid = 1'b0;
    check("last_strobe", {31'd0, imem_write_enable}, 32'd1);
    check("hold_at_last_strobe", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    check("hold_released", {31'd0, cpu_hold}, 32'd0);
    check("done_set", {31'd0, load_done}, 32'd1);
    check("imem_pc_pass", imem_pc, 32'h0000_0040);
    check("rx_ready_done", {31'd0, rx_ready}, 32'd0);
    check("queue_drained", exp_addr_q.size(), 32'd0);
  endtask

  initial begin
    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, imem_write_enable}, 32'd0);
    check("rst_addr", imem_write_addr, 32'd0);
    check("rst_data", imem_write_data, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_error", {31'd0, load_error}, 32'd0);
    check("rst_imem_pc", imem_pc, 32'd0);
    reset = 1'b0;

    // 2: N=2 load
    pulse_start();
    check("hdr_rx_ready", {31'd0, rx_ready}, 32'd1);
    load_two(1'b0);

    // 3: same load with rx_valid gaps
    pulse_start();
    check("reload_hold", {31'd0, cpu_hold}, 32'd1);
    check("reload_done_clr", {31'd0, load_done}, 32'd0);
    check("reload_imem_pc", imem_pc, 32'd0);
    load_two(1'b1);
    check("hold_addr", imem_write_addr, 32'd1);
    check("hold_data", imem_write_data, 32'h0020_0593);

    // 4: header exceeds SIZE
    pulse_start();
    send_word(32'h0000_0101, 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    check("err_flag", {31'd0, load_error}, 32'd1);
    check("err_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("err_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (4) @(negedge clk);
    check("err_stays_not_ready", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1'b0;

    // 5: N=0 then N=1 reload
    pulse_start();
    check("err_cleared", {31'd0, load_error}, 32'd0);
    send_word(32'd0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("n0_done", {31'd0, load_done}, 32'd1);
    check("n0_hold", {31'd0, cpu_hold}, 32'd0);
    pulse_start();
    expect_write(32'd0, 32'hDDCC_BBAA);
    send_word(32'd1, 1'b0);
    send_word(32'hDDCC_BBAA, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("n1_done", {31'd0, load_done}, 32'd1);
    check("n1_queue", exp_addr_q.size(), 32'd0);

    // 6: reset after 6 bytes of an N=2 load
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_rst_done", {31'd0, load_done}, 32'd0);
    repeat (6) @(negedge clk);
    check("mid_rst_idle_ready", {31'd0, rx_ready}, 32'd0);
    check("final_queue", exp_addr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
